serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle bit-serial subtractor. Computes diff = a - b - bin one bit per clock, LSB first.
//   It is the subtract-direction counterpart to the combinational ripple adders in the datapath.
//   It trades WIDTH cycles of latency for a single full-subtractor cell.
//   It sits behind a start/busy/done handshake so a controller FSM can issue operations.
// PARAMETERS
//   WIDTH    4    operand and result width in bits (>=2)
// PORTS
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      request; sampled only when busy=0
//   a        in   WIDTH  minuend (unsigned or two's complement)
//   b        in   WIDTH  subtrahend
//   bin      in   1      borrow in
//   diff     out  WIDTH  result, (a - b - bin) mod 2^WIDTH
//   bout     out  1      borrow out: 1 iff a < b + bin (unsigned compare)
//   busy     out  1      operation in progress
//   done     out  1      one-cycle pulse; diff/bout valid from this cycle
//   ovf      out  1      signed overflow (present only with SERSUB_OVF_EN)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE; diff=0, bout=0, busy=0, done=0, ovf=0; internal regs cleared.
//   - FSM states: IDLE, RUN.
//   - IDLE, start=1 at an edge: latch a, b and bin into shift/borrow regs; bit counter=0; busy<=1; go to RUN.
//   - RUN, each edge: process bit[cnt].
//     - d = x ^ y ^ br.
//     - br <= (~x & y) | (~x & br) | (y & br).
//     - shift d into the result reg MSB; cnt++.
//   - RUN, WIDTH-th edge: write diff and bout (final borrow); busy<=0; done<=1; go to IDLE.
//   - Latency: done is high exactly WIDTH+1 cycles after the cycle start was sampled.
//     For WIDTH=4: start seen at edge 0, done=1 after edge 4.
//   - done is high for exactly one cycle; it falls at the next edge.
//   - diff/bout hold their value until the next completion or reset.
//   - start while busy=1: ignored. Operands are not re-latched and nothing is queued.
//   - start in the done cycle (busy=0): accepted (back-to-back).
//     done falls, busy rises, and diff/bout keep the old result until the new completion.
//   - Input changes on a/b/bin after the start edge have no effect on the result.
//   - Reset asserted mid-RUN: abort immediately, all outputs to their reset values, no done pulse.
//   - Bit counter is clog2(WIDTH)+1 bits. It never wraps, because RUN exits at cnt==WIDTH-1.
// CONFIGURATION
//   SERSUB_OVF_EN defined:
//     - ovf port exists.
//     - On completion, ovf <= (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using latched operands; bin is included in diff.
//     - ovf is valid with done and held like diff.
//   SERSUB_OVF_EN undefined:
//     - ovf port and its logic are absent.
//     - All other behaviour and timing are identical.
// TESTING
//   T1: WIDTH=4, a=9, b=5, bin=0, start pulse -> after 5 cycles done=1, diff=4, bout=0.
//   T2: a=3, b=5, bin=0 -> diff=14, bout=1. Also a=0, b=0, bin=1 -> diff=15, bout=1.
//   T3: busy window -> busy high exactly 4 cycles.
//       start re-pulsed with a=1, b=1 during busy -> result still from first operands, single done.
//   T4: back-to-back: start held high through done cycle with a=7, b=2 -> second done 5 cycles later, diff=5.
//   T5: reset asserted at the 2nd RUN cycle -> busy=0, done=0, diff=0 at once.
//       No done pulse follows; a new start then works normally.
//   T6 (SERSUB_OVF_EN): a=8 (-8), b=1 -> diff=7, ovf=1. Also a=4, b=2 -> diff=2, ovf=0.
//   Random: 1000 operands versus reference model (a-b-bin), all WIDTH in {2,4,8}.

Source files
------------

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial subtractor, diff = a - b - bin, one bit per clock, LSB
//            first, behind a start/busy/done handshake. Optional signed
//            overflow output enabled by defining SERSUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int C_CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_res;
  logic               r_br;
  logic [C_CNT_W-1:0] r_cnt;
`ifdef SERSUB_OVF_EN
  logic               r_amsb;
  logic               r_bmsb;
`endif

  // Single full-subtractor cell working on the current LSBs of the operand shifters
  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_x       = r_x[0];
  assign w_y       = r_y[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_nxt  = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
  assign w_last    = (r_cnt == C_CNT_W'(WIDTH - 1));
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERSUB_OVF_EN
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= a;
            r_y     <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
`ifdef SERSUB_OVF_EN
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_x   <= r_x >> 1;
          r_y   <= r_y >> 1;
          r_br  <= w_br_nxt;
          r_res <= w_res_nxt;
          r_cnt <= r_cnt + C_CNT_W'(1);
          if (w_last) begin
            // The bit produced on this edge is the result MSB
            diff    <= w_res_nxt;
            bout    <= w_br_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
`ifdef SERSUB_OVF_EN
            ovf     <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
